alu_result_merge: RTL and testbench
===================================

// Module: alu_result_merge
// PURPOSE
//  Sits directly downstream of the per-container ALU array in one RMT action stage.
//  Buffers each incoming PHV while its actions execute in the ALUs.
//  Collects one container_out result per issued ALU and writes it back into the buffered PHV.
//  Emits the updated PHV in order to the next stage; detects lost, orphan and duplicate results.
// PARAMETERS
//  CONT_NUM    8   number of containers/ALUs merged
//  DATA_WIDTH  32  container width (bits)
//  META_LEN    32  metadata bits carried unchanged above the containers
//  FIFO_DEPTH  4   buffered PHVs in flight (power of 2)
//  TIMEOUT     15  max cycles an entry waits in COLLECT before forced emit
// PORTS
//  clk                 in   1                      clock
//  rst                 in   1                      synchronous active-high reset
//  phv_in              in   META_LEN+CONT_NUM*DW   PHV; container i at [i*DW +: DW], meta on top
//  phv_in_valid        in   1                      PHV issued (same cycle its actions go to ALUs)
//  alu_issue_mask      in   CONT_NUM               bit i=1: ALU i got action_valid for this PHV
//  container_in        in   CONT_NUM*DW            ALU results, ALU i at [i*DW +: DW]
//  container_in_valid  in   CONT_NUM               per-ALU result strobe (1 cycle)
//  ready_out           out  1                      =~fifo_full; upstream issues only when high
//  phv_out             out  META_LEN+CONT_NUM*DW   merged PHV
//  phv_out_valid       out  1                      1-cycle strobe
//  err_overflow        out  1                      sticky: phv_in_valid while full
//  err_orphan          out  1                      sticky: result strobe with FIFO empty
//  err_dup             out  1                      sticky: 2nd strobe on already-collected slot
//  err_timeout         out  1                      sticky: forced emit occurred
// BEHAVIOUR
//  - Reset (sync, rst=1): all outputs 0, FIFO empty, flags/counters 0, state IDLE; in-flight
//    entries and partial results discarded. ready_out=1 from first cycle after rst deasserts.
//  - Push: phv_in_valid & ~full writes {mask,phv_in}. phv_in_valid & full -> dropped, err_overflow.
//    No same-cycle push-on-pop bypass when full.
//  - Result capture for FIFO head: each cycle,
//      got <= (clr ? 0 : got) | (container_in_valid & mask_head);
//      res[i] <= container_in[i] when valid[i].
//    Strobes on unmasked slots are ignored. Strobe on slot with got[i] already 1 (and no clr)
//    -> value dropped, err_dup.
//  - FSM:
//    - IDLE: FIFO empty. Any strobe -> err_orphan, dropped. FIFO non-empty -> COLLECT, tmo=0.
//    - COLLECT: tmo++ each cycle.
//      - got==mask_head (incl. mask 0): register phv_out = head PHV with slot i replaced by
//        res[i] where mask[i]; -> EMIT.
//      - tmo==TIMEOUT: same, but missing slots keep original container; err_timeout=1; -> EMIT.
//    - EMIT: phv_out_valid=1 for this cycle only; pop head; clr=1 (got cleared, strobes this
//      cycle still captured for next head). -> COLLECT (tmo=0) if entries remain after pop,
//      else IDLE.
//  - Latency: last required strobe sampled in cycle T -> phv_out_valid in T+2.
//    Mask-0 entry reaching head in COLLECT at cycle H -> output at H+1.
//  - Order strictly FIFO. Metadata passes unmodified. phv_out holds its value between strobes.
//  - Error flags clear only on rst.
// TESTING
//  1. rst; push mask=8'h01, cont0=5; cont0 result 7 two cycles later (cycle T)
//     -> phv_out_valid at T+2, cont0=7, others/meta unchanged.
//  2. Push mask=8'hFF; strobes spread over 3 cycles, mixed values
//     -> single emit 2 cycles after last strobe, all 8 replaced.
//  3. Push 5 PHVs back-to-back with no results (depth 4)
//     -> ready_out=0 after 4th, 5th dropped, err_overflow=1; each head force-emitted after
//        TIMEOUT with originals, err_timeout=1.
//  4. Strobe with FIFO empty -> err_orphan=1, no phv_out_valid.
//     Duplicate strobe on cont2 (first 3, then 9) -> output 3, err_dup=1.
//  5. Two queued PHVs; strobe for 2nd entry lands in the 1st entry's EMIT cycle
//     -> 2nd entry emits with that value, no err_dup.
//  6. Assert rst mid-COLLECT with 2 entries queued
//     -> next cycle all outputs 0, ready_out=1; later strobes flag err_orphan.

Source files
------------

// File: rtl/alu_result_merge.sv
// alu_result_merge: buffers PHVs while their ALU actions run, merges the per-container
// results back in, and emits them in order with lost/orphan/duplicate result detection.
module alu_result_merge #(
    parameter int CONT_NUM   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int META_LEN   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [META_LEN+CONT_NUM*DATA_WIDTH-1:0] phv_in,
    input  logic                                   phv_in_valid,
    input  logic [CONT_NUM-1:0]                    alu_issue_mask,
    input  logic [CONT_NUM*DATA_WIDTH-1:0]         container_in,
    input  logic [CONT_NUM-1:0]                    container_in_valid,
    output logic                                   ready_out,
    output logic [META_LEN+CONT_NUM*DATA_WIDTH-1:0] phv_out,
    output logic                                   phv_out_valid,
    output logic                                   err_overflow,
    output logic                                   err_orphan,
    output logic                                   err_dup,
    output logic                                   err_timeout
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = META_LEN + CONT_NUM * DW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    logic [PW-1:0]       phv_mem [FIFO_DEPTH];
    logic [CONT_NUM-1:0] mask_mem [FIFO_DEPTH];
    logic [DW-1:0]       res [CONT_NUM];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count, count_next;
    logic [TW-1:0]       tmo;
    logic [CONT_NUM-1:0] got, base, mask_eff, cap, dup;
    logic [PW-1:0]       merged;
    logic                full, empty, push, pop, done;
    state_t              state;

    assign full       = count == DEPTH;
    assign empty      = count == '0;
    assign ready_out  = ~full;
    assign push       = phv_in_valid & ~full;
    assign pop        = state == EMIT;
    assign count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);
    assign done       = got == mask_mem[rd_ptr];

    // During EMIT the head is leaving, so strobes already belong to the entry behind it.
    assign mask_eff = pop ? (count > (AW + 1)'(1) ? mask_mem[rd_ptr + AW'(1)] : '0)
                          : (empty ? '0 : mask_mem[rd_ptr]);
    assign base     = pop ? '0 : got;
    assign cap      = container_in_valid & mask_eff & ~base;
    assign dup      = container_in_valid & mask_eff & base;

    always_comb begin
        merged = phv_mem[rd_ptr];
        for (int i = 0; i < CONT_NUM; i++)
            if (got[i]) merged[i*DW +: DW] = res[i];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            phv_mem[wr_ptr]  <= phv_in;
            mask_mem[wr_ptr] <= alu_issue_mask;
        end
        for (int i = 0; i < CONT_NUM; i++)
            if (cap[i]) res[i] <= container_in[i*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            got           <= '0;
            tmo           <= '0;
            phv_out       <= '0;
            phv_out_valid <= 1'b0;
            err_overflow  <= 1'b0;
            err_orphan    <= 1'b0;
            err_dup       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            got           <= base | cap;
            count         <= count_next;
            wr_ptr        <= wr_ptr + AW'(push);
            rd_ptr        <= rd_ptr + AW'(pop);
            phv_out_valid <= 1'b0;
            err_overflow  <= err_overflow | (phv_in_valid & full);
            err_orphan    <= err_orphan | (empty & |container_in_valid);
            err_dup       <= err_dup | |dup;
            case (state)
                IDLE: if (!empty) begin
                    state <= COLLECT;
                    tmo   <= '0;
                end
                COLLECT: begin
                    tmo <= tmo + TW'(1);
                    if (done || tmo == TW'(TIMEOUT)) begin
                        phv_out       <= merged;
                        phv_out_valid <= 1'b1;
                        err_timeout   <= err_timeout | ~done;
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    state <= count_next != '0 ? COLLECT : IDLE;
                    tmo   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_merge.sv
// tb_alu_result_merge: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of the merge stage.
module tb_alu_result_merge;
    localparam int CN = 8;
    localparam int DW = 32;
    localparam int ML = 32;
    localparam int FD = 4;
    localparam int TO = 15;
    localparam int CW = CN * DW;
    localparam int PW = ML + CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] phv_in = '0;
    logic          phv_in_valid = 1'b0;
    logic [CN-1:0] alu_issue_mask = '0;
    logic [CW-1:0] container_in = '0;
    logic [CN-1:0] container_in_valid = '0;
    logic          ready_out, phv_out_valid;
    logic [PW-1:0] phv_out;
    logic          err_overflow, err_orphan, err_dup, err_timeout;

    int checks = 0;
    int fails = 0;

    alu_result_merge #(.CONT_NUM(CN), .DATA_WIDTH(DW), .META_LEN(ML), .FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .alu_issue_mask(alu_issue_mask), .container_in(container_in),
        .container_in_valid(container_in_valid), .ready_out(ready_out), .phv_out(phv_out),
        .phv_out_valid(phv_out_valid), .err_overflow(err_overflow), .err_orphan(err_orphan),
        .err_dup(err_dup), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of waiting PHVs, the results gathered for the head,
    // and how long the head has been waiting.
    logic [PW-1:0] qp[$];
    logic [CN-1:0] qm[$];
    logic [DW-1:0] m_res [CN];
    logic [CN-1:0] m_got, tgt, old, nb;
    logic [PW-1:0] m_phv;
    logic          m_emit, m_active, m_ovf, m_orph, m_dup, m_tmo, was_emit, pushing, chk_en = 1'b0;
    int            m_age, sz;

    always @(posedge clk) begin
        if (rst) begin
            qp.delete();
            qm.delete();
            m_got = '0; m_active = 0; m_age = 0; m_emit = 0; m_phv = '0;
            m_ovf = 0; m_orph = 0; m_dup = 0; m_tmo = 0;
            chk_en = 1'b1;
        end else begin
            sz = qp.size();
            tgt = m_emit ? (sz > 1 ? qm[1] : '0) : (sz > 0 ? qm[0] : '0);
            was_emit = m_emit;
            old = m_got;
            pushing = phv_in_valid && sz < FD;
            if (m_emit) begin
                void'(qp.pop_front());
                void'(qm.pop_front());
                m_emit = 0;
                m_active = (qp.size() + (pushing ? 1 : 0)) > 0;
                m_age = 0;
            end else if (m_active) begin
                if (old == qm[0] || m_age == TO) begin
                    if (old != qm[0]) m_tmo = 1;
                    m_phv = qp[0];
                    for (int i = 0; i < CN; i++)
                        if (old[i]) m_phv[i*DW +: DW] = m_res[i];
                    m_emit = 1;
                    m_active = 0;
                end else m_age++;
            end else if (sz > 0) begin
                m_active = 1;
                m_age = 0;
            end
            if (sz == 0 && container_in_valid != '0) m_orph = 1;
            nb = was_emit ? '0 : old;
            for (int i = 0; i < CN; i++)
                if (container_in_valid[i] && tgt[i]) begin
                    if (nb[i]) m_dup = 1;
                    else begin
                        nb[i] = 1'b1;
                        m_res[i] = container_in[i*DW +: DW];
                    end
                end
            m_got = nb;
            if (phv_in_valid) begin
                if (sz == FD) m_ovf = 1;
                else begin
                    qp.push_back(phv_in);
                    qm.push_back(alu_issue_mask);
                end
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        checks++;
        if ({phv_out_valid, phv_out} !== {m_emit, m_phv}) begin
            fails++;
            $display("FAIL model_out t=%0t: got v=%b %h want v=%b %h", $time, phv_out_valid, phv_out, m_emit, m_phv);
        end
        checks++;
        if ({ready_out, err_overflow, err_orphan, err_dup, err_timeout} !==
            {qp.size() < FD, m_ovf, m_orph, m_dup, m_tmo}) begin
            fails++;
            $display("FAIL model_flags t=%0t: got %b want %b", $time,
                     {ready_out, err_overflow, err_orphan, err_dup, err_timeout},
                     {qp.size() < FD, m_ovf, m_orph, m_dup, m_tmo});
        end
    end

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [31:0] meta, input logic [31:0] b);
        logic [PW-1:0] p;
        p[PW-1 -: ML] = meta;
        for (int i = 0; i < CN; i++) p[i*DW +: DW] = b + 32'(i);
        return p;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [CN-1:0] m, input logic [PW-1:0] p);
        phv_in = p; alu_issue_mask = m; phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in_valid = 1'b0;
    endtask

    task automatic strobe(input logic [CN-1:0] v, input logic [CW-1:0] c);
        container_in = c; container_in_valid = v;
        @(negedge clk);
        container_in_valid = '0;
    endtask

    logic [PW-1:0] p1, p2, c2, pa, pb, pd, e, cv;
    logic [PW-1:0] p3 [5];
    int n;

    initial begin
        idle(2);
        rst = 1'b0;
        chk("reset_outputs", PW'({phv_out_valid, err_overflow, err_orphan, err_dup, err_timeout}), '0);
        chk("reset_ready", PW'(ready_out), PW'(1));

        // single masked container, result two cycles after issue
        p1 = mk(32'hA000_0001, 32'h5);
        push(8'h01, p1);
        idle(1);
        cv = '0; cv[31:0] = 32'h7;
        strobe(8'h01, cv[CW-1:0]);
        chk("t1_not_yet", PW'(phv_out_valid), '0);
        idle(1);
        e = p1; e[31:0] = 32'h7;
        chk("t1_valid", PW'(phv_out_valid), PW'(1));
        chk("t1_data", phv_out, e);
        idle(2);

        // full mask, strobes over three cycles
        p2 = mk(32'hB000_0002, 32'h100);
        c2 = mk(32'h0, 32'hC000_0000);
        push(8'hFF, p2);
        idle(1);
        strobe(8'h07, c2[CW-1:0]);
        strobe(8'h38, c2[CW-1:0]);
        strobe(8'hC0, c2[CW-1:0]);
        chk("t2_not_yet", PW'(phv_out_valid), '0);
        idle(1);
        e = p2; e[CW-1:0] = c2[CW-1:0];
        chk("t2_valid", PW'(phv_out_valid), PW'(1));
        chk("t2_data", phv_out, e);
        idle(2);

        // result for the second entry arrives during the first entry's emit cycle
        pa = mk(32'hD000_000A, 32'h200);
        pb = mk(32'hD000_000B, 32'h300);
        push(8'h01, pa);
        push(8'h02, pb);
        cv = '0; cv[31:0] = 32'h55; cv[63:32] = 32'h66;
        strobe(8'h01, cv[CW-1:0]);
        idle(1);
        e = pa; e[31:0] = 32'h55;
        chk("t5_first", phv_out, e);
        strobe(8'h02, cv[CW-1:0]);
        idle(1);
        e = pb; e[63:32] = 32'h66;
        chk("t5_second_valid", PW'(phv_out_valid), PW'(1));
        chk("t5_second", phv_out, e);
        chk("t5_no_dup", PW'(err_dup), '0);
        idle(2);

        // orphan then duplicate
        strobe(8'hFF, cv[CW-1:0]);
        chk("t4_orphan", PW'({err_orphan, phv_out_valid}), PW'(2'b10));
        pd = mk(32'hE000_0004, 32'hF);
        push(8'h04, pd);
        idle(1);
        cv = '0; cv[95:64] = 32'h3;
        strobe(8'h04, cv[CW-1:0]);
        cv[95:64] = 32'h9;
        strobe(8'h04, cv[CW-1:0]);
        e = pd; e[95:64] = 32'h3;
        chk("t4_dup_data", phv_out, e);
        chk("t4_dup_flag", PW'({err_dup, phv_out_valid}), PW'(2'b11));
        idle(2);

        // overflow and forced emits
        for (int k = 0; k < 5; k++) begin
            p3[k] = mk(32'hF000_0000 + 32'(k), 32'h3000 + 32'(k * 16));
            push(8'h0F, p3[k]);
            if (k == 3) chk("t3_full", PW'(ready_out), '0);
        end
        chk("t3_overflow", PW'(err_overflow), PW'(1));
        n = 0;
        for (int c = 0; c < 150 && n < 4; c++) begin
            idle(1);
            if (phv_out_valid) begin
                chk("t3_forced", phv_out, p3[n]);
                n++;
            end
        end
        chk("t3_count", PW'(n), PW'(4));
        chk("t3_timeout", PW'(err_timeout), PW'(1));
        idle(2);

        // reset with entries in flight
        push(8'h01, p1);
        push(8'h02, p2);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t6_out", phv_out, '0);
        chk("t6_flags", PW'({phv_out_valid, err_overflow, err_orphan, err_dup, err_timeout}), '0);
        chk("t6_ready", PW'(ready_out), PW'(1));
        strobe(8'h03, cv[CW-1:0]);
        chk("t6_orphan", PW'(err_orphan), PW'(1));

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 699) == 0);
            phv_in_valid = ($urandom_range(0, 2) == 0);
            for (int j = 0; j < PW / 32; j++) phv_in[j*32 +: 32] = $urandom;
            alu_issue_mask = CN'($urandom & $urandom);
            container_in_valid = CN'($urandom & $urandom);
            for (int j = 0; j < CN; j++) container_in[j*DW +: DW] = $urandom;
            @(negedge clk);
        end
        rst = 1'b0; phv_in_valid = 1'b0; container_in_valid = '0;
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
